alu_driver: RTL and testbench

- Issuer for the 12-bit accumulator-ALU instruction interface: {opcode[11:8], imm[7:0]} on `inst`/`inst_en`, 8-bit accumulator returned on `result`.
- Buffers host instructions in a small FIFO and issues them one at a time, honouring the ALU's post-reset start-up cycle.
- Captures the accumulator after each issue and returns it to the host through a valid/ready handshake.
- Sits between the host/command path and the ALU instance.

---
 rtl/alu_driver_if.sv | 20 ++
 rtl/alu_driver.sv | 140 ++++++++++++++
 tb/tb_alu_driver.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_driver_if.sv
// Host-side bundle for alu_driver: instruction push
// handshake and result return handshake.
interface alu_driver_if;
  logic [11:0] in_inst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_result;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_inst, in_valid, out_ready,
    input  in_ready, out_result, out_valid
  );

  modport slave (
    input  in_inst, in_valid, out_ready,
    output in_ready, out_result, out_valid
  );
endinterface

// File: rtl/alu_driver.sv
// Instruction issuer for the accumulator ALU: FIFO, start-up delay, result return.
// Optional: define ALU_DRIVER_NOPSKIP_EN to drop NOP words instead of issuing them.
module alu_driver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int START_DELAY = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  alu_driver_if.slave      host,
  output logic [11:0]      inst,
  output logic             inst_en,
  input  logic [7:0]       alu_result,
  output logic [CNT_W-1:0] issued_count,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(START_DELAY + 1);

  typedef enum logic [2:0] {
    INIT, IDLE, ISSUE, WAIT, HOLD
  } state_t;

  state_t state_q, state_d;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;
  logic          full, empty;
  logic          push, pop;
  logic [11:0]   head;

  logic [DW-1:0]    dly_q, dly_d;
  logic [11:0]      inst_q, inst_d;
  logic             en_q, en_d;
  logic [7:0]       res_q, res_d;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go, skip;

  assign full  = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign empty = (fcnt == '0);
  assign head  = mem[rd_ptr];

  assign host.in_ready = reset & ~full;
  assign push = host.in_valid & host.in_ready;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= host.in_inst;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fcnt <= fcnt + 1'b1;
      else if (pop && !push) fcnt <= fcnt - 1'b1;
    end
  end

`ifdef ALU_DRIVER_NOPSKIP_EN
  assign skip = (head[11:8] == 4'h0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    inst_d  = inst_q;
    en_d    = 1'b0;
    res_d   = res_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      INIT: begin
        if (dly_q == DW'(START_DELAY - 1)) state_d = IDLE;
        else dly_d = dly_q + 1'b1;
      end
      IDLE:  go = ~empty;
      ISSUE: state_d = WAIT;
      WAIT: begin
        res_d   = alu_result;
        ov_d    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (host.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
          go      = ~empty;
        end
      end
      default: state_d = INIT;
    endcase
    // A skipped head is still popped; IDLE then looks at the next one.
    if (go) begin
      pop = 1'b1;
      if (!skip) begin
        inst_d  = head;
        en_d    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = ISSUE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      dly_q   <= '0;
      inst_q  <= '0;
      en_q    <= 1'b0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      inst_q  <= inst_d;
      en_q    <= en_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst            = inst_q;
  assign inst_en         = en_q;
  assign host.out_result = res_q;
  assign host.out_valid  = ov_q;
  assign issued_count    = cnt_q;
  assign busy = reset & ((state_q != IDLE) | ~empty);
endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver with a behavioural
// accumulator ALU and a result scoreboard.
module tb_alu_driver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] inst;
  logic        inst_en;
  logic [7:0]  alu_result;
  logic [7:0]  issued_count;
  logic        busy;

  int assertions = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] acc;
  logic [7:0] ref_acc = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];

`ifdef ALU_DRIVER_NOPSKIP_EN
  localparam bit NOPSKIP = 1'b1;
`else
  localparam bit NOPSKIP = 1'b0;
`endif

  alu_driver_if host();

  alu_driver #(
    .FIFO_DEPTH(4),
    .START_DELAY(2),
    .CNT_W(8)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .host(host),
    .inst(inst),
    .inst_en(inst_en),
    .alu_result(alu_result),
    .issued_count(issued_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [7:0] a,
                                       input logic [11:0] w);
    case (w[11:8])
      4'h1:    return w[7:0];
      4'h2:    return a + w[7:0];
      4'h3:    return a ^ w[7:0];
      4'h4:    return a & w[7:0];
      default: return a;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= 8'h00;
    else if (inst_en) acc <= alu_f(acc, inst);
  end
  assign alu_result = acc;

  always @(negedge clk) begin
    if (rst_n && host.out_valid && host.out_ready) begin
      got_q.push_back(host.out_result);
      got_cyc.push_back(cyc);
    end
  end

  task automatic push_word(input logic [11:0] w);
    int n = 0;
    host.in_inst = w;
    host.in_valid = 1'b1;
    while (!host.in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!host.in_ready) begin
      assertions++;
      failures++;
      $display("FAIL push_timeout: in_ready=%b required 1", host.in_ready);
      host.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!(NOPSKIP && w[11:8] == 4'h0)) begin
      ref_acc = alu_f(ref_acc, w);
      exp_q.push_back(ref_acc);
    end
  endtask

  task automatic wait_got(input int n, input int limit);
    int k = 0;
    while (got_q.size() < n && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (got_q.size() < n) begin
      assertions++;
      failures++;
      $display("FAIL result_timeout: got %0d results required %0d",
               got_q.size(), n);
    end
  endtask

  task automatic apply_reset();
    host.in_valid = 1'b0;
    host.out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    ref_acc = 8'h00;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    assertions++;
    if ({inst, inst_en, host.out_result, host.out_valid,
         issued_count, busy, host.in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: inst=%h en=%b res=%h ov=%b cnt=%h busy=%b rdy=%b required all 0",
               inst, inst_en, host.out_result, host.out_valid,
               issued_count, busy, host.in_ready);
    end
  endtask

  task automatic test_startup();
    logic [7:0] g, e;
    @(posedge clk); #1;
    rst_n = 1'b1;
    host.out_ready = 1'b1;
    host.in_inst = 12'h112;
    host.in_valid = 1'b1;
    @(posedge clk); #1;
    host.in_valid = 1'b0;
    ref_acc = alu_f(ref_acc, 12'h112);
    exp_q.push_back(ref_acc);
    assertions++;
    if (inst_en !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL init_edge1: en=%b busy=%b required en=0 busy=1",
               inst_en, busy);
    end
    @(posedge clk); #1;
    assertions++;
    if (inst_en !== 1'b0) begin
      failures++;
      $display("FAIL init_edge2: en=%b required 0", inst_en);
    end
    @(posedge clk); #1;
    assertions++;
    if (inst_en !== 1'b1 || inst !== 12'h112 || issued_count !== 8'd1) begin
      failures++;
      $display("FAIL first_issue: en=%b inst=%h cnt=%0d required 1 112 1",
               inst_en, inst, issued_count);
    end
    @(posedge clk); #1;
    assertions++;
    if (inst_en !== 1'b0 || inst !== 12'h112) begin
      failures++;
      $display("FAIL strobe_one_cycle: en=%b inst=%h required 0 112",
               inst_en, inst);
    end
    @(posedge clk); #1;
    assertions++;
    if (host.out_valid !== 1'b1 || host.out_result !== 8'h12 ||
        issued_count !== 8'd1) begin
      failures++;
      $display("FAIL first_result: ov=%b res=%h cnt=%0d required 1 12 1",
               host.out_valid, host.out_result, issued_count);
    end
    wait_got(1, 10);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc.pop_front());
      assertions++;
      if (g !== e) begin
        failures++;
        $display("FAIL startup_sb: got %h required %h", g, e);
      end
    end
  endtask

  task automatic test_sequence();
    int c [3];
    logic [7:0] g, e;
    host.out_ready = 1'b1;
    push_word(12'h112);
    push_word(12'h205);
    push_word(12'h304);
    host.in_valid = 1'b0;
    wait_got(3, 40);
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        c[i] = got_cyc.pop_front();
        assertions++;
        if (g !== e) begin
          failures++;
          $display("FAIL seq_result%0d: got %h required %h", i, g, e);
        end
      end
    end
    for (int i = 1; i < 3; i++) begin
      assertions++;
      if (c[i] - c[i-1] != 3) begin
        failures++;
        $display("FAIL seq_spacing%0d: got %0d cycles required 3",
                 i, c[i] - c[i-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g, e, held;
    host.out_ready = 1'b0;
    push_word(12'h121);
    push_word(12'h203);
    push_word(12'h30F);
    push_word(12'h4F0);
    push_word(12'h211);
    assertions++;
    if (host.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full: in_ready=%b required 0", host.in_ready);
    end
    held = exp_q[0];
    host.in_inst = 12'h1FF;
    host.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      assertions++;
      if (host.in_ready !== 1'b0 || host.out_valid !== 1'b1 ||
          host.out_result !== held || got_q.size() != 0) begin
        failures++;
        $display("FAIL hold_stable%0d: rdy=%b ov=%b res=%h required 0 1 %h",
                 i, host.in_ready, host.out_valid, host.out_result, held);
      end
    end
    host.in_valid = 1'b0;
    host.out_ready = 1'b1;
    wait_got(5, 60);
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        void'(got_cyc.pop_front());
        assertions++;
        if (g !== e) begin
          failures++;
          $display("FAIL drain%0d: got %h required %h", i, g, e);
        end
      end
    end
  endtask

  task automatic test_nop();
    int n;
    logic [7:0] g, e;
    apply_reset();
    host.out_ready = 1'b1;
    push_word(12'h1AA);
    push_word(12'h000);
    push_word(12'h455);
    host.in_valid = 1'b0;
    n = NOPSKIP ? 2 : 3;
    wait_got(n, 40);
    repeat (6) @(posedge clk);
    #1;
    assertions++;
    if (got_q.size() != n || issued_count !== 8'(n)) begin
      failures++;
      $display("FAIL nop_count: results=%0d cnt=%0d required %0d",
               got_q.size(), issued_count, n);
    end
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        void'(got_cyc.pop_front());
        assertions++;
        if (g !== e) begin
          failures++;
          $display("FAIL nop_result%0d: got %h required %h", i, g, e);
        end
      end
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_async_reset();
    bit strobe = 1'b0;
    host.out_ready = 1'b0;
    push_word(12'h133);
    push_word(12'h201);
    push_word(12'h202);
    host.in_valid = 1'b0;
    assertions++;
    if (inst_en !== 1'b0 || host.out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_state: en=%b ov=%b busy=%b required 0 0 1",
               inst_en, host.out_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    assertions++;
    if ({inst_en, host.out_valid, busy, issued_count} !== '0) begin
      failures++;
      $display("FAIL async_clear: en=%b ov=%b busy=%b cnt=%0d required 0",
               inst_en, host.out_valid, busy, issued_count);
    end
    @(posedge clk); #1;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    ref_acc = 8'h00;
    rst_n = 1'b1;
    host.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (inst_en) strobe = 1'b1;
    end
    assertions++;
    if (strobe || busy !== 1'b0 || host.in_ready !== 1'b1 ||
        got_q.size() != 0 || issued_count !== 8'd0) begin
      failures++;
      $display("FAIL fifo_flushed: strobe=%b busy=%b rdy=%b results=%0d cnt=%0d required 0 0 1 0 0",
               strobe, busy, host.in_ready, got_q.size(), issued_count);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    logic [7:0] g, e, last;
    last = 8'hFF;
    host.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) push_word(12'h201);
    host.in_valid = 1'b0;
    wait_got(256, 200);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc.pop_front());
      last = g;
      assertions++;
      if (g !== e) begin
        failures++;
        if (bad < 4)
          $display("FAIL wrap_result: got %h required %h", g, e);
        bad++;
      end
    end
    assertions++;
    if (issued_count !== 8'd0 || last !== 8'h00) begin
      failures++;
      $display("FAIL count_wrap: cnt=%0d last=%h required 0 00",
               issued_count, last);
    end
  endtask

  initial begin
    host.in_inst = '0;
    host.in_valid = 1'b0;
    host.out_ready = 1'b0;
    test_reset();
    test_startup();
    test_sequence();
    test_back_to_back();
    test_nop();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end
endmodule
